// File: rtl/dp_mc_if.sv
// Instruction handshake, memory-operand port and status outputs of dp_mc.
// The slave modport is the datapath side; master is the decoder/RAM side.
interface dp_mc_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  parameter int IMMW  = 21,
  parameter int ADDRW = 10
);
  localparam int RA = $clog2(NREGS);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alucode;
  logic [RA-1:0]    op1;
  logic [RA-1:0]    op2_reg;
  logic [IMMW-1:0]  imm;
  logic             imm_sel;
  logic             src1_mem;
  logic             src2_mem;
  logic             reg_we;
  logic             wb_sel;
  logic [2:0]       pc_ctrl;
  logic [RA-1:0]    br_reg;
  logic [ADDRW-1:0] mem_addr;
  logic             mem_rd;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_rvalid;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             div0;

  modport slave (
    input  in_valid, alucode, op1, op2_reg, imm, imm_sel, src1_mem, src2_mem,
           reg_we, wb_sel, pc_ctrl, br_reg, mem_rdata, mem_rvalid,
    output in_ready, mem_addr, mem_rd, pc, result, done, div0
  );

  modport master (
    output in_valid, alucode, op1, op2_reg, imm, imm_sel, src1_mem, src2_mem,
           reg_we, wb_sel, pc_ctrl, br_reg, mem_rdata, mem_rvalid,
    input  in_ready, mem_addr, mem_rd, pc, result, done, div0
  );
endinterface

// File: rtl/dp_mc.sv
// Multi-cycle datapath: register file, ALU, restoring divider, branch/PC unit
// and a variable-latency memory-operand port, one instruction in flight.
module dp_mc #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  parameter int IMMW  = 21,
  parameter int ADDRW = 10
) (
  input  logic   clock,
  input  logic   reset_n,
  dp_mc_if.slave bus
);
  localparam int RA = $clog2(NREGS);
  localparam int SH = $clog2(WIDTH);
  localparam logic [SH-1:0]    CNT_ONE  = {{(SH-1){1'b0}}, 1'b1};
  localparam logic [SH-1:0]    CNT_LAST = {SH{1'b1}};
  localparam logic [WIDTH-1:0] PC_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, RD1, RD2, EXEC, WB} state_t;

  function automatic logic [WIDTH-1:0] sext(input logic [IMMW-1:0] v);
    return {{(WIDTH-IMMW){v[IMMW-1]}}, v};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] regs_r [NREGS];
  logic [3:0]       alucode_r;
  logic [RA-1:0]    op1_r, op2_r, br_reg_r;
  logic [IMMW-1:0]  imm_r;
  logic             imm_sel_r, src1_mem_r, src2_mem_r, reg_we_r, wb_sel_r;
  logic [2:0]       pc_ctrl_r;
  logic [WIDTH-1:0] mem1_r, num1_r, num2_r, quo_r, rem_r;
  logic [SH-1:0]    cnt_r;
  logic [WIDTH-1:0] pc_r, result_r;
  logic             done_r, div0_r, in_ready_r, mem_rd_r;
  logic [ADDRW-1:0] mem_addr_r;

  logic [RA-1:0]    f_op1_s, f_op2_s;
  logic [IMMW-1:0]  f_imm_s;
  logic             f_imm_sel_s, f_src1_s, f_src2_s;
  logic [WIDTH-1:0] n1_s, n2_s, alu_s, quo_nx_s, rem_nx_s;
  logic [WIDTH:0]   shifted_s, diff_s;
  logic             taken_s, div_op_s;

  assign bus.in_ready = in_ready_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_rd   = mem_rd_r;
  assign bus.pc       = pc_r;
  assign bus.result   = result_r;
  assign bus.done     = done_r;
  assign bus.div0     = div0_r;

  // Operand selection; in IDLE the fields come straight from the decoder.
  always_comb begin
    if (state_r == IDLE) begin
      f_op1_s     = bus.op1;
      f_op2_s     = bus.op2_reg;
      f_imm_s     = bus.imm;
      f_imm_sel_s = bus.imm_sel;
      f_src1_s    = bus.src1_mem;
      f_src2_s    = bus.src2_mem;
    end else begin
      f_op1_s     = op1_r;
      f_op2_s     = op2_r;
      f_imm_s     = imm_r;
      f_imm_sel_s = imm_sel_r;
      f_src1_s    = src1_mem_r;
      f_src2_s    = src2_mem_r;
    end
    if (f_src1_s) begin
      if (state_r == RD1) n1_s = bus.mem_rdata;
      else                n1_s = mem1_r;
    end else begin
      n1_s = regs_r[f_op1_s];
    end
    // Entering EXEC with a memory num2 only happens from RD2, on the rvalid edge.
    if (f_imm_sel_s)   n2_s = sext(f_imm_s);
    else if (f_src2_s) n2_s = bus.mem_rdata;
    else               n2_s = regs_r[f_op2_s];
  end

  // Single-cycle ALU; ops 4/5 here only cover the divide-by-zero outcome.
  always_comb begin
    alu_s = ONES;
    case (alucode_r)
      4'd0:    alu_s = num1_r;
      4'd1:    alu_s = num1_r + num2_r;
      4'd2:    alu_s = num1_r - num2_r;
      4'd3:    alu_s = num1_r * num2_r;
      4'd4:    alu_s = ONES;
      4'd5:    alu_s = num1_r;
      4'd6:    alu_s = num1_r | num2_r;
      4'd7:    alu_s = num1_r & num2_r;
      4'd8:    alu_s = num1_r ^ num2_r;
      4'd9:    alu_s = ~num1_r;
      4'd10:   alu_s = num1_r >> 1'b1;
      4'd11:   alu_s = num1_r << 1'b1;
      4'd12:   alu_s = $unsigned($signed(num1_r) >>> num2_r[SH-1:0]);
      4'd13:   alu_s = num1_r << num2_r[SH-1:0];
      4'd14:   alu_s = {{(WIDTH-1){1'b0}}, ($signed(num1_r) < $signed(num2_r))};
      default: alu_s = ONES;
    endcase
  end

  // One restoring-division step; bit WIDTH of diff is set when the trial subtract underflows.
  always_comb begin
    div_op_s  = (alucode_r == 4'd4) || (alucode_r == 4'd5);
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, num2_r};
    if (!diff_s[WIDTH]) begin
      rem_nx_s = diff_s[WIDTH-1:0];
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx_s = shifted_s[WIDTH-1:0];
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Branch condition, unsigned compare of the two operands.
  always_comb begin
    taken_s = 1'b0;
    case (pc_ctrl_r)
      3'd0:    taken_s = 1'b0;
      3'd1:    taken_s = (num1_r == num2_r);
      3'd2:    taken_s = (num1_r <  num2_r);
      3'd3:    taken_s = (num1_r >  num2_r);
      3'd4:    taken_s = (num1_r != num2_r);
      3'd5:    taken_s = (num1_r <= num2_r);
      3'd6:    taken_s = (num1_r >= num2_r);
      3'd7:    taken_s = 1'b1;
      default: taken_s = 1'b0;
    endcase
  end

  // Control FSM together with all architectural state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      for (int i = 0; i < NREGS; i++) regs_r[i] <= ZERO;
      alucode_r  <= 4'd0;
      op1_r      <= {RA{1'b0}};
      op2_r      <= {RA{1'b0}};
      br_reg_r   <= {RA{1'b0}};
      imm_r      <= {IMMW{1'b0}};
      imm_sel_r  <= 1'b0;
      src1_mem_r <= 1'b0;
      src2_mem_r <= 1'b0;
      reg_we_r   <= 1'b0;
      wb_sel_r   <= 1'b0;
      pc_ctrl_r  <= 3'd0;
      mem1_r     <= ZERO;
      num1_r     <= ZERO;
      num2_r     <= ZERO;
      quo_r      <= ZERO;
      rem_r      <= ZERO;
      cnt_r      <= {SH{1'b0}};
      pc_r       <= ZERO;
      result_r   <= ZERO;
      done_r     <= 1'b0;
      div0_r     <= 1'b0;
      in_ready_r <= 1'b1;
      mem_rd_r   <= 1'b0;
      mem_addr_r <= {ADDRW{1'b0}};
    end else begin
      // Operands track their sources until EXEC is entered, freezing the values then.
      if (state_r == IDLE || state_r == RD1 || state_r == RD2) begin
        num1_r <= n1_s;
        num2_r <= n2_s;
        quo_r  <= n1_s;
        rem_r  <= ZERO;
        cnt_r  <= {SH{1'b0}};
      end
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            alucode_r  <= bus.alucode;
            op1_r      <= bus.op1;
            op2_r      <= bus.op2_reg;
            br_reg_r   <= bus.br_reg;
            imm_r      <= bus.imm;
            imm_sel_r  <= bus.imm_sel;
            src1_mem_r <= bus.src1_mem;
            src2_mem_r <= bus.src2_mem;
            reg_we_r   <= bus.reg_we;
            wb_sel_r   <= bus.wb_sel;
            pc_ctrl_r  <= bus.pc_ctrl;
            in_ready_r <= 1'b0;
            if (bus.src1_mem) begin
              state_r    <= RD1;
              mem_rd_r   <= 1'b1;
              mem_addr_r <= regs_r[bus.op1][ADDRW-1:0];
            end else if (bus.src2_mem && !bus.imm_sel) begin
              state_r    <= RD2;
              mem_rd_r   <= 1'b1;
              mem_addr_r <= regs_r[bus.op2_reg][ADDRW-1:0];
            end else begin
              state_r <= EXEC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD1: begin
          if (bus.mem_rvalid) begin
            mem1_r <= bus.mem_rdata;
            if (src2_mem_r && !imm_sel_r) begin
              state_r    <= RD2;
              mem_addr_r <= regs_r[op2_r][ADDRW-1:0];
            end else begin
              state_r  <= EXEC;
              mem_rd_r <= 1'b0;
            end
          end else begin
            state_r <= RD1;
          end
        end
        RD2: begin
          if (bus.mem_rvalid) begin
            state_r  <= EXEC;
            mem_rd_r <= 1'b0;
          end else begin
            state_r <= RD2;
          end
        end
        EXEC: begin
          if (div_op_s && (num2_r != ZERO)) begin
            quo_r <= quo_nx_s;
            rem_r <= rem_nx_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              result_r <= (alucode_r == 4'd4) ? quo_nx_s : rem_nx_s;
              done_r   <= 1'b1;
              state_r  <= WB;
            end else begin
              state_r <= EXEC;
            end
          end else begin
            result_r <= alu_s;
            div0_r   <= div_op_s;
            done_r   <= 1'b1;
            state_r  <= WB;
          end
        end
        WB: begin
          done_r     <= 1'b0;
          div0_r     <= 1'b0;
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
          if (reg_we_r) regs_r[op1_r] <= wb_sel_r ? num2_r : result_r;
          // Offset is read before the write-back lands, so br_reg == op1 sees the old value.
          pc_r <= pc_r + (taken_s ? regs_r[br_reg_r] : PC_ONE);
        end
        default: begin
          state_r    <= IDLE;
          done_r     <= 1'b0;
          div0_r     <= 1'b0;
          mem_rd_r   <= 1'b0;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end
endmodule
